fp_add_sched: RTL
=================

Name: fp_add_sched

Overview:
- Two-requester scheduler and sequencer for the shared multi-cycle single-precision adder datapath (align, add, normalize, round).
- Arbitrates operand pairs from requesters A and B with round-robin priority.
- Steps the datapath through its stages with one-hot stage enables, including one renormalize pass when rounding carries out.
- Returns the result, overflow flag and requester ID through a valid/ready response port.

Parameters:
- NORM_TIMEOUT, 32, max cycles NORM/RENORM may wait for dp_norm_done before abort
- TO_W, 6, width of timeout counter; must hold NORM_TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  asynchronous active-low reset
- a_valid  in  1  requester A operand pair valid
- a_ready  out  1  requester A accepted this cycle
- a_x, a_y  in  32  requester A IEEE-754 operands
- b_valid  in  1  requester B operand pair valid
- b_ready  out  1  requester B accepted this cycle
- b_x, b_y  in  32  requester B operands
- dp_x, dp_y  out  32  operands driven to datapath, held from grant to DONE
- dp_stage  out  4  one-hot stage enable: [0] align, [1] add, [2] normalize, [3] round
- dp_norm_done  in  1  datapath normalize shift complete
- dp_round_carry  in  1  rounding carried into bit 24 (renormalize needed)
- dp_result  in  32  packed datapath result
- dp_overflow  in  1  exponent overflow from datapath
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  0 = A, 1 = B
- resp_result  out  32  result
- resp_overflow  out  1  overflow flag
- resp_abort  out  1  normalize timeout occurred; resp_result forced 0

Behaviour:
- Reset (res low, asynchronous): state IDLE; all outputs 0; rr_last = 1, so A wins first.
- IDLE:
  - If one valid is high, grant it.
  - If both are high, grant the requester not equal to rr_last.
  - Pulse the granted x_ready for 1 cycle, latch its operands into dp_x/dp_y, record the ID, update rr_last, go to ALIGN.
  - ready is never high outside IDLE or while resp_valid is high.
- ALIGN: dp_stage = 0001 for 1 cycle, then ADD.
- ADD: dp_stage = 0010 for 1 cycle, then NORM.
- NORM:
  - dp_stage = 0100; wait for dp_norm_done; timeout counter counts up from 0.
  - done goes to ROUND.
  - Counter reaching NORM_TIMEOUT-1 without done goes to DONE with abort = 1.
- ROUND:
  - dp_stage = 1000 for 1 cycle.
  - dp_round_carry = 1 and renorm flag clear: set flag, go to RENORM.
  - Otherwise capture dp_result and dp_overflow, go to DONE.
- RENORM:
  - Same as NORM (counter restarts at 0); done goes back to ROUND.
  - The renorm flag prevents a second pass; a carry on the second ROUND is ignored and the result captured.
- DONE:
  - resp_valid = 1; resp_* held stable until resp_valid && resp_ready, then IDLE.
  - Back-to-back grant is possible on the cycle after acceptance.
- Latency, grant to resp_valid, when dp_norm_done arrives in the first NORM cycle: 5 cycles; with renormalize: 7 cycles.
- dp_stage is 0000 in IDLE and DONE.
- An asserted valid with no grant must be held by the requester; the scheduler never drops a request.
- Overflow capture: resp_overflow = dp_overflow sampled in the capturing ROUND cycle.
- Abort: resp_result = 0, resp_overflow = 0, resp_abort = 1.
- Reset mid-operation: immediate return to IDLE; in-flight request lost; no response issued; rr_last = 1.

Optional Feature:
- Macro: FP_ADD_ZERO_BYPASS_EN.
- Defined: in IDLE at grant, if the latched x or y has bits[30:0] = 0, go directly to DONE next cycle.
  - resp_result = the other operand; if both are zero, result = x & y, so sign = AND of signs.
  - Overflow 0; dp_stage stays 0000; latency 1.
- Undefined: zero operands take the full datapath sequence.

Test Plan:
- A only, x = 0x3F800000, y = 0x3F800000; model returns 0x40000000, norm_done immediately, no carry -> resp_id 0, resp_result 0x40000000, resp_valid 5 cycles after a_ready, dp_stage sequence 0001, 0010, 0100, 1000.
- A and B valid together three times, resp_ready tied high -> grants A, B, A; each ready is a single-cycle pulse.
- Model asserts dp_round_carry on every ROUND -> exactly one RENORM pass, result captured on the second ROUND, latency 7.
- dp_norm_done never asserted -> resp_abort = 1 and resp_result 0 after NORM_TIMEOUT NORM cycles; next request serviced normally.
- resp_ready held low 10 cycles in DONE; model dp_overflow = 1 -> resp_* stable and resp_overflow = 1 throughout, no new ready pulses; resp_ready high -> IDLE.
- res pulled low during NORM -> all outputs 0 asynchronously; after release, B-only request served with id 1; with FP_ADD_ZERO_BYPASS_EN defined, x = 0x00000000, y = 0x40490FDB -> result 0x40490FDB, latency 1.

Source files
------------

// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin scheduler and stage sequencer for a shared multi-cycle FP adder
// Optional feature macro: FP_ADD_ZERO_BYPASS_EN (zero operand skips the datapath, result in one cycle)
module fp_add_sched #(
  parameter int NORM_TIMEOUT = 32,
  parameter int TO_W         = 6
) (
  input  logic        clk,
  input  logic        res,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_x,
  input  logic [31:0] a_y,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_x,
  input  logic [31:0] b_y,
  output logic [31:0] dp_x,
  output logic [31:0] dp_y,
  output logic [3:0]  dp_stage,
  input  logic        dp_norm_done,
  input  logic        dp_round_carry,
  input  logic [31:0] dp_result,
  input  logic        dp_overflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_overflow,
  output logic        resp_abort
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_RENORM, S_DONE
  } state_t;

  state_t          state, state_n;
  logic            run;        // low for the first cycle after reset so ready stays 0 during reset
  logic            rr_last;    // ID of the last requester granted
  logic            renorm;     // one renormalize pass already taken for this operation
  logic [TO_W-1:0] to_cnt;
  logic            gnt_id;
  logic [31:0]     sel_x, sel_y;
  logic            take, cap, abort, set_renorm, cnt_inc;

  // Winner if a grant happens this cycle: the only requester, or the one not granted last
  assign gnt_id = (a_valid && b_valid) ? ~rr_last : b_valid;
  assign sel_x  = gnt_id ? b_x : a_x;
  assign sel_y  = gnt_id ? b_y : a_y;

`ifdef FP_ADD_ZERO_BYPASS_EN
  logic        x_zero, y_zero, byp;
  logic [31:0] byp_result;
  assign x_zero     = (sel_x[30:0] == 31'd0);
  assign y_zero     = (sel_y[30:0] == 31'd0);
  // Both zero: AND keeps the sign rule of IEEE addition of two zeros
  assign byp_result = (x_zero && y_zero) ? (sel_x & sel_y) : (x_zero ? sel_y : sel_x);
`endif

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next state, stage enables, handshakes and datapath control strobes
  always_comb begin
    state_n    = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    dp_stage   = 4'b0000;
    resp_valid = 1'b0;
    take       = 1'b0;
    cap        = 1'b0;
    abort      = 1'b0;
    set_renorm = 1'b0;
    cnt_inc    = 1'b0;
`ifdef FP_ADD_ZERO_BYPASS_EN
    byp        = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (run && (a_valid || b_valid)) begin
          take    = 1'b1;
          a_ready = ~gnt_id;
          b_ready = gnt_id;
          state_n = S_ALIGN;
`ifdef FP_ADD_ZERO_BYPASS_EN
          if (x_zero || y_zero) begin
            byp     = 1'b1;
            state_n = S_DONE;
          end
`endif
        end
      end
      S_ALIGN: begin
        dp_stage = 4'b0001;
        state_n  = S_ADD;
      end
      S_ADD: begin
        dp_stage = 4'b0010;
        state_n  = S_NORM;
      end
      S_NORM, S_RENORM: begin
        dp_stage = 4'b0100;
        if (dp_norm_done) begin
          state_n = S_ROUND;
        end else if (to_cnt == TO_W'(NORM_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_ROUND: begin
        dp_stage = 4'b1000;
        if (dp_round_carry && !renorm) begin
          set_renorm = 1'b1;
          state_n    = S_RENORM;
        end else begin
          cap     = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operand latch, arbitration history, timeout counter and response capture
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      run           <= 1'b0;
      rr_last       <= 1'b1;
      renorm        <= 1'b0;
      to_cnt        <= '0;
      dp_x          <= 32'd0;
      dp_y          <= 32'd0;
      resp_id       <= 1'b0;
      resp_result   <= 32'd0;
      resp_overflow <= 1'b0;
      resp_abort    <= 1'b0;
    end else begin
      run    <= 1'b1;
      // Counter only runs while waiting on normalize; any other cycle restarts it at 0
      to_cnt <= cnt_inc ? to_cnt + 1'b1 : '0;
      if (take) begin
        dp_x          <= sel_x;
        dp_y          <= sel_y;
        resp_id       <= gnt_id;
        rr_last       <= gnt_id;
        renorm        <= 1'b0;
        resp_result   <= 32'd0;
        resp_overflow <= 1'b0;
        resp_abort    <= 1'b0;
      end
      if (set_renorm) renorm <= 1'b1;
      if (cap) begin
        resp_result   <= dp_result;
        resp_overflow <= dp_overflow;
        resp_abort    <= 1'b0;
      end
      if (abort) begin
        resp_result   <= 32'd0;
        resp_overflow <= 1'b0;
        resp_abort    <= 1'b1;
      end
`ifdef FP_ADD_ZERO_BYPASS_EN
      if (byp) resp_result <= byp_result;
`endif
    end
  end

endmodule
